mem_wb_skid_stage: RTL and testbench
====================================

Name: mem_wb_skid_stage

Overview:
- Parametrised successor to the MEM/WB pipeline register.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, synchronous flush and halt drain control.
- Adds a write-back data mux at the output.
- Sits between data-memory access and the register-file write port.

Parameters:
- DATA_W, 32, width of alu_result / read_data / wb_data.
- REG_ADDR_W, 5, width of destination register number.
- ZERO_REG_SUPPRESS, 1: when 1, reg_write is forced to 0 at capture if rd_num == 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_alu_result  in  DATA_W  ALU result
- in_read_data  in  DATA_W  memory load data
- in_rd_num  in  REG_ADDR_W  destination register
- in_mem_to_reg  in  1  select load data for write-back
- in_reg_write  in  1  register write enable
- in_halted  in  1  halt instruction marker
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts
- out_alu_result / out_read_data  out  DATA_W  registered payload
- out_rd_num  out  REG_ADDR_W  registered destination
- out_mem_to_reg  out  1  registered select
- out_reg_write  out  1  registered write enable, gated by out_valid
- out_halted  out  1  registered halt marker, gated by out_valid
- out_wb_data  out  DATA_W  out_mem_to_reg ? out_read_data : out_alu_result
- halted_sticky  out  1  a halted beat has left the stage

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset: main_valid=0, skid_valid=0, halt_seen=0, halted_sticky=0, and all payload registers 0.
  - All outputs therefore read 0 during reset, including in_ready (forced 0 while rst_n low).
- Transfers: input when in_valid && in_ready; output when out_valid && out_ready.
- in_ready = rst_n && !skid_valid && !halt_seen && !halted_sticky.
  - Depends only on registers, never on out_ready.
- out_valid = main_valid.
- Latency: a beat accepted at edge N appears on the outputs after edge N (1 cycle) if main is empty or draining. Throughput is 1 beat per cycle.
- Per-edge update, in priority order:
  1. flush=1: main_valid=0, skid_valid=0, halt_seen=0; any input beat in that cycle is discarded; halted_sticky unchanged; payload registers unchanged.
  2. main empty or draining (out_ready=1):
     - skid_valid=1: main<=skid, skid_valid<=accept; skid<=input if accept.
     - skid_valid=0: main<=input, main_valid<=accept.
  3. main full and stalled (out_ready=0): an accepted input goes to skid, skid_valid=1.
- Ordering: beats leave in arrival order. Never drop, never duplicate.
- Payload: held when out_valid=0. out_reg_write and out_halted are ANDed with out_valid so the register file never writes a stale beat.
- ZERO_REG_SUPPRESS applies at capture into skid or main.
- Halt handling:
  - halt_seen is set when a beat with in_halted=1 is accepted; further input is blocked.
  - halted_sticky is set on the output transfer of a beat with out_halted=1. It is cleared only by reset and blocks input permanently.
  - Flush before delivery discards the halted beat and clears halt_seen.
- Simultaneous flush and output transfer: the transfer counts downstream; no state update beyond the flush.
- Reset asserted mid-stall: all buffered beats are lost; outputs return to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: MEM_WB_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cycles, 32 bits, reset 0.
  - Increments every cycle with out_valid && !out_ready; saturates at all-ones.
  - Unaffected by flush.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Streaming: in_valid=1, out_ready=1, 4 beats with alu_result 0x10,0x20,0x30,0x40, mem_to_reg=0 -> out_valid from the cycle after the first accept; out_wb_data 0x10..0x40 on consecutive cycles; in_ready stays 1.
- Back-pressure: out_ready=0 after beat A=0x11 is in main, then send B=0x22 -> B is taken into skid, in_ready=0 next cycle. Then out_ready=1 -> outputs A then B, and in_ready returns to 1.
- Mux and zero-reg: rd_num=0, reg_write=1, mem_to_reg=1, read_data=0xDEADBEEF -> out_reg_write=0 and out_wb_data=0xDEADBEEF. Repeat with rd_num=5 -> out_reg_write=1.
- Flush: main and skid both full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed beats never appear.
- Halt: send a halted beat then 2 more beats -> in_ready=0 after the halt accept; halted_sticky=1 after out_ready takes it; the subsequent beats are never accepted. Async rst_n pulse -> halted_sticky=0, in_ready=1.
- With MEM_WB_STALL_CNT_EN: hold out_ready=0 for 7 cycles with main valid -> stall_cycles=7.

Source files
------------

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline stage with a valid/ready handshake, a 2-entry skid buffer, flush, halt drain and a write-back mux.
// Optional MEM_WB_STALL_CNT_EN adds a saturating back-pressure cycle counter (stall_cycles).
//
//  main_v skid_v | meaning
//  0      0      | empty, accepting
//  1      0      | one beat presented downstream, still accepting
//  1      1      | full, in_ready low until main drains
module mem_wb_skid_stage #(
    parameter int DATA_W            = 32,
    parameter int REG_ADDR_W        = 5,
    parameter int ZERO_REG_SUPPRESS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_read_data,
    input  logic [REG_ADDR_W-1:0] in_rd_num,
    input  logic                  in_mem_to_reg,
    input  logic                  in_reg_write,
    input  logic                  in_halted,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_read_data,
    output logic [REG_ADDR_W-1:0] out_rd_num,
    output logic                  out_mem_to_reg,
    output logic                  out_reg_write,
    output logic                  out_halted,
    output logic [DATA_W-1:0]     out_wb_data,
    output logic                  halted_sticky
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     rdata;
        logic [REG_ADDR_W-1:0] rd;
        logic                  m2r;
        logic                  rw;
        logic                  halted;
    } beat_t;

    localparam bit ZRS = (ZERO_REG_SUPPRESS != 0);

    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    logic  halt_seen_q, halt_seen_d;
    logic  halted_sticky_q, halted_sticky_d;

    beat_t in_beat;
    logic  accept;
    logic  out_fire;

    assign in_ready = rst_n && !skid_valid_q && !halt_seen_q && !halted_sticky_q;
    assign accept   = in_valid && in_ready;
    assign out_fire = main_valid_q && out_ready;

    // Writes to register zero are dropped here so the write port never sees them.
    always_comb begin
        in_beat.alu    = in_alu_result;
        in_beat.rdata  = in_read_data;
        in_beat.rd     = in_rd_num;
        in_beat.m2r    = in_mem_to_reg;
        in_beat.rw     = in_reg_write && !(ZRS && (in_rd_num == '0));
        in_beat.halted = in_halted;
    end

    always_comb begin
        main_d          = main_q;
        skid_d          = skid_q;
        main_valid_d    = main_valid_q;
        skid_valid_d    = skid_valid_q;
        halt_seen_d     = halt_seen_q;
        halted_sticky_d = halted_sticky_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            halt_seen_d  = 1'b0;
        end else begin
            if (out_fire && main_q.halted)
                halted_sticky_d = 1'b1;
            if (accept && in_halted)
                halt_seen_d = 1'b1;

            if (!main_valid_q || out_ready) begin
                if (skid_valid_q) begin
                    main_d       = skid_q;
                    main_valid_d = 1'b1;
                    skid_valid_d = accept;
                    if (accept)
                        skid_d = in_beat;
                end else begin
                    main_valid_d = accept;
                    if (accept)
                        main_d = in_beat;
                end
            end else if (accept) begin
                skid_d       = in_beat;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q          <= '0;
            skid_q          <= '0;
            main_valid_q    <= 1'b0;
            skid_valid_q    <= 1'b0;
            halt_seen_q     <= 1'b0;
            halted_sticky_q <= 1'b0;
        end else begin
            main_q          <= main_d;
            skid_q          <= skid_d;
            main_valid_q    <= main_valid_d;
            skid_valid_q    <= skid_valid_d;
            halt_seen_q     <= halt_seen_d;
            halted_sticky_q <= halted_sticky_d;
        end
    end

    assign out_valid      = main_valid_q;
    assign out_alu_result = main_q.alu;
    assign out_read_data  = main_q.rdata;
    assign out_rd_num     = main_q.rd;
    assign out_mem_to_reg = main_q.m2r;
    assign out_reg_write  = main_q.rw && main_valid_q;
    assign out_halted     = main_q.halted && main_valid_q;
    assign out_wb_data    = main_q.m2r ? main_q.rdata : main_q.alu;
    assign halted_sticky  = halted_sticky_q;

`ifdef MEM_WB_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (main_valid_q && !out_ready && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles_q <= '0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed bench for mem_wb_skid_stage: vector table for streaming, back-pressure and mux cases,
// then hand-written flush, halt and asynchronous-reset sequences.
module tb_mem_wb_skid_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_alu_result;
    logic [31:0] in_read_data;
    logic [4:0]  in_rd_num;
    logic        in_mem_to_reg;
    logic        in_reg_write;
    logic        in_halted;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_alu_result;
    logic [31:0] out_read_data;
    logic [4:0]  out_rd_num;
    logic        out_mem_to_reg;
    logic        out_reg_write;
    logic        out_halted;
    logic [31:0] out_wb_data;
    logic        halted_sticky;
`ifdef MEM_WB_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    mem_wb_skid_stage #(.DATA_W(32), .REG_ADDR_W(5), .ZERO_REG_SUPPRESS(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_result  (in_alu_result),
        .in_read_data   (in_read_data),
        .in_rd_num      (in_rd_num),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_reg_write   (in_reg_write),
        .in_halted      (in_halted),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_result (out_alu_result),
        .out_read_data  (out_read_data),
        .out_rd_num     (out_rd_num),
        .out_mem_to_reg (out_mem_to_reg),
        .out_reg_write  (out_reg_write),
        .out_halted     (out_halted),
        .out_wb_data    (out_wb_data),
        .halted_sticky  (halted_sticky)
`ifdef MEM_WB_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        iv;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_wb;
        logic        e_rw;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic m2r, input logic rw,
                         input logic hlt, input logic ordy, input logic fl);
        in_valid      = iv;
        in_alu_result = alu;
        in_read_data  = rdata;
        in_rd_num     = rd;
        in_mem_to_reg = m2r;
        in_reg_write  = rw;
        in_halted     = hlt;
        out_ready     = ordy;
        flush         = fl;
    endtask

    function automatic vec_t mk(logic iv, logic [31:0] alu, logic [31:0] rdata, logic [4:0] rd,
                                logic m2r, logic rw, logic ordy, logic e_ov, logic e_ir,
                                logic [31:0] e_wb, logic e_rw);
        vec_t v;
        v.iv = iv; v.alu = alu; v.rdata = rdata; v.rd = rd; v.m2r = m2r; v.rw = rw;
        v.ordy = ordy; v.e_ov = e_ov; v.e_ir = e_ir; v.e_wb = e_wb; v.e_rw = e_rw;
        return v;
    endfunction

    initial begin
        //            iv  alu          rdata         rd  m2r rw ordy | ov ir wb           rw
        vecs[0]  = mk(1, 32'h10,       32'h0,        1,  0,  1, 1,     1, 1, 32'h10,       1);
        vecs[1]  = mk(1, 32'h20,       32'h0,        1,  0,  1, 1,     1, 1, 32'h20,       1);
        vecs[2]  = mk(1, 32'h30,       32'h0,        1,  0,  1, 1,     1, 1, 32'h30,       1);
        vecs[3]  = mk(1, 32'h40,       32'h0,        1,  0,  1, 1,     1, 1, 32'h40,       1);
        vecs[4]  = mk(0, 32'h0,        32'h0,        0,  0,  0, 1,     0, 1, 32'h40,       0);
        vecs[5]  = mk(1, 32'h11,       32'h0,        2,  0,  1, 1,     1, 1, 32'h11,       1);
        vecs[6]  = mk(1, 32'h22,       32'h0,        2,  0,  1, 0,     1, 0, 32'h11,       1);
        vecs[7]  = mk(0, 32'h0,        32'h0,        0,  0,  0, 0,     1, 0, 32'h11,       1);
        vecs[8]  = mk(0, 32'h0,        32'h0,        0,  0,  0, 1,     1, 1, 32'h22,       1);
        vecs[9]  = mk(0, 32'h0,        32'h0,        0,  0,  0, 1,     0, 1, 32'h22,       0);
        vecs[10] = mk(1, 32'h55,       32'hDEADBEEF, 0,  1,  1, 0,     1, 1, 32'hDEADBEEF, 0);
        vecs[11] = mk(1, 32'h66,       32'hDEADBEEF, 5,  1,  1, 1,     1, 1, 32'hDEADBEEF, 1);
        vecs[12] = mk(0, 32'h0,        32'h0,        0,  0,  0, 1,     0, 1, 32'hDEADBEEF, 0);
        vecs[13] = mk(1, 32'h1234,     32'hFFFF0000, 3,  0,  1, 1,     1, 1, 32'h1234,     1);
        vecs[14] = mk(0, 32'h0,        32'h0,        0,  0,  0, 1,     0, 1, 32'h1234,     0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_wb_data", out_wb_data, 32'd0);
        chk("rst_sticky", {31'b0, halted_sticky}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].iv, vecs[i].alu, vecs[i].rdata, vecs[i].rd, vecs[i].m2r,
                  vecs[i].rw, 1'b0, vecs[i].ordy, 1'b0);
            step();
            chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
            chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
            chk($sformatf("v%0d_wb_data", i), out_wb_data, vecs[i].e_wb);
            chk($sformatf("v%0d_reg_write", i), {31'b0, out_reg_write}, {31'b0, vecs[i].e_rw});
        end

        // Flush with main and skid both full and a beat offered in the same cycle.
        drive(1, 32'hA1, 0, 1, 0, 1, 0, 0, 0); step();
        drive(1, 32'hA2, 0, 1, 0, 1, 0, 0, 0); step();
        chk("fl_full_ov", {31'b0, out_valid}, 32'd1);
        chk("fl_full_ir", {31'b0, in_ready}, 32'd0);
        drive(1, 32'hA3, 0, 1, 0, 1, 0, 0, 1); step();
        chk("fl_ov", {31'b0, out_valid}, 32'd0);
        chk("fl_ir", {31'b0, in_ready}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("fl_gone%0d", i), {31'b0, out_valid}, 32'd0);
        end
        drive(1, 32'hB1, 0, 1, 0, 1, 0, 1, 0); step();
        chk("fl_next_ov", {31'b0, out_valid}, 32'd1);
        chk("fl_next_wb", out_wb_data, 32'hB1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        chk("fl_drain_ov", {31'b0, out_valid}, 32'd0);

        // Halt: halted beat stalls, later beats blocked, sticky after it leaves.
        drive(1, 32'hC1, 0, 4, 0, 1, 1, 0, 0); step();
        chk("h_ir", {31'b0, in_ready}, 32'd0);
        chk("h_out_halted", {31'b0, out_halted}, 32'd1);
        chk("h_sticky0", {31'b0, halted_sticky}, 32'd0);
        drive(1, 32'hC2, 0, 4, 0, 1, 0, 0, 0); step();
        chk("h_blk_ir", {31'b0, in_ready}, 32'd0);
        chk("h_blk_wb", out_wb_data, 32'hC1);
        drive(1, 32'hC3, 0, 4, 0, 1, 0, 1, 0); step();
        chk("h_sticky1", {31'b0, halted_sticky}, 32'd1);
        chk("h_ov_after", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("h_never%0d_ov", i), {31'b0, out_valid}, 32'd0);
            chk($sformatf("h_never%0d_ir", i), {31'b0, in_ready}, 32'd0);
        end
        rst_n = 1'b0;
        #2;
        chk("h_rst_sticky", {31'b0, halted_sticky}, 32'd0);
        chk("h_rst_ir_low", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("h_rst_ir", {31'b0, in_ready}, 32'd1);

        // Reset while stalled with both entries full: beats lost, outputs cleared without an edge.
        drive(1, 32'hE1, 32'h7, 6, 1, 1, 0, 0, 0); step();
        drive(1, 32'hE2, 0, 6, 0, 1, 0, 0, 0); step();
        chk("rs_full_ir", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #2;
        chk("rs_ov", {31'b0, out_valid}, 32'd0);
        chk("rs_wb", out_wb_data, 32'd0);
        chk("rs_rw", {31'b0, out_reg_write}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        step();
        chk("rs_lost_ov", {31'b0, out_valid}, 32'd0);

`ifdef MEM_WB_STALL_CNT_EN
        drive(1, 32'hF1, 0, 1, 0, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (7) step();
        chk("stall_cnt7", stall_cycles, 32'd7);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0); step();
        chk("stall_hold", stall_cycles, 32'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
